mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit; reads the EX/MEM pipeline register outputs and performs the data-memory access for the instruction held there.
- Drives a req/ack data-memory bus with byte-lane formatting, and sign/zero-extends load data for MEM/WB.
- Returns `mem_stall` to the hazard unit so EX/MEM and earlier stages hold while an access is outstanding.

---
 rtl/pipe_defs_pkg.sv | 29 ++
 rtl/lsu_align.sv | 55 +++++
 rtl/mem_stage_lsu.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_defs_pkg.sv
// Shared pipeline definitions: memory-size encodings from the EX/MEM
// register and the MEM-stage load/store unit state type.
package pipe_defs_pkg;

   // Load size encodings carried in EXMEMMemRBits (2'b11 is treated as word)
   localparam logic [1:0] MEM_R_WORD = 2'b00;
   localparam logic [1:0] MEM_R_HALF = 2'b01;
   localparam logic [1:0] MEM_R_BYTE = 2'b10;

   // Store size encodings carried in EXMEMMemWrBits (one-hot; others = no store)
   localparam logic [2:0] MEM_W_BYTE = 3'b001;
   localparam logic [2:0] MEM_W_HALF = 3'b010;
   localparam logic [2:0] MEM_W_WORD = 3'b100;

   // Normalised access size shared by loads and stores
   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } mem_size_t;

   // Load/store unit FSM states
   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_WAIT,
      LSU_DONE
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting for the MEM-stage LSU: byte enables, lane-replicated
// store data, misalignment detection and load extraction/extension.
module lsu_align
   import pipe_defs_pkg::*;
(
   input  mem_size_t   size,
   input  logic        sign,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wd,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic        misalign,
   output logic [31:0] load_ext
);

   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   // Lane selection of the addressed byte and halfword from the read word
   always_comb begin
      case (addr_lo)
         2'd0:    sel_b = rdata[7:0];
         2'd1:    sel_b = rdata[15:8];
         2'd2:    sel_b = rdata[23:16];
         default: sel_b = rdata[31:24];
      endcase
      sel_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Size-dependent enables, write replication, alignment and extension
   always_comb begin
      be        = 4'b1111;
      wdata_rep = wd;
      misalign  = 1'b0;
      load_ext  = rdata;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wd[7:0]}};
            load_ext  = {{24{sign & sel_b[7]}}, sel_b};
         end
         SZ_HALF: begin
            be        = 4'b0011 << addr_lo;
            wdata_rep = {2{wd[15:0]}};
            misalign  = addr_lo[0];
            load_ext  = {{16{sign & sel_h[15]}}, sel_h};
         end
         default: begin
            misalign  = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one req/ack data-memory access per
// EX/MEM instruction, formats lanes, extends load data and stalls the
// pipeline until the access has completed, failed alignment or timed out.
module mem_stage_lsu
   import pipe_defs_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EXMEMMemRead,
   input  logic        EXMEMMemWrite,
   input  logic [1:0]  EXMEMMemRBits,
   input  logic        EXMEMMemRSign,
   input  logic [2:0]  EXMEMMemWrBits,
   input  logic [31:0] EXMEMALUResult,
   input  logic [31:0] EXMEMMemWriteData,
   input  logic        mem_advance,
   output logic        dm_req,
   output logic        dm_we,
   output logic [29:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic [31:0] mem_load_data,
   output logic        mem_stall,
   output logic        mem_misalign,
   output logic        mem_bus_err
);

   lsu_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt;

   logic      wr_ok, is_store, op_valid;
   mem_size_t live_size, lat_size, a_size;
   logic      lat_sign, a_sign;
   logic [1:0] lat_lo, a_lo;

   logic [3:0]  a_be;
   logic [31:0] a_wdata, a_load;
   logic        a_misalign;

   logic cnt_last, issue, mis_set, got_ack, tmo, done_rel;

   // Decode the EX/MEM request; a valid store overrides a simultaneous load
   always_comb begin
      wr_ok    = (EXMEMMemWrBits == MEM_W_BYTE) || (EXMEMMemWrBits == MEM_W_HALF) ||
                 (EXMEMMemWrBits == MEM_W_WORD);
      is_store = EXMEMMemWrite & wr_ok;
      op_valid = EXMEMMemRead | is_store;
      live_size = SZ_WORD;
      if (is_store) begin
         case (EXMEMMemWrBits)
            MEM_W_BYTE: live_size = SZ_BYTE;
            MEM_W_HALF: live_size = SZ_HALF;
            default:    live_size = SZ_WORD;
         endcase
      end else begin
         case (EXMEMMemRBits)
            MEM_R_BYTE: live_size = SZ_BYTE;
            MEM_R_HALF: live_size = SZ_HALF;
            MEM_R_WORD: live_size = SZ_WORD;
            default:    live_size = SZ_WORD;
         endcase
      end
   end

   // One formatter serves both phases: live inputs at issue, latched ones
   // afterwards so EX/MEM changes during WAIT cannot corrupt load extraction
   always_comb begin
      if (state == LSU_IDLE) begin
         a_size = live_size;
         a_sign = EXMEMMemRSign;
         a_lo   = EXMEMALUResult[1:0];
      end else begin
         a_size = lat_size;
         a_sign = lat_sign;
         a_lo   = lat_lo;
      end
   end

   lsu_align u_align (
      .size      (a_size),
      .sign      (a_sign),
      .addr_lo   (a_lo),
      .wd        (EXMEMMemWriteData),
      .rdata     (dm_rdata),
      .be        (a_be),
      .wdata_rep (a_wdata),
      .misalign  (a_misalign),
      .load_ext  (a_load)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= LSU_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         LSU_IDLE: if (op_valid) state_nx = a_misalign ? LSU_DONE : LSU_WAIT;
         LSU_WAIT: if (dm_ack || cnt_last) state_nx = LSU_DONE;
         LSU_DONE: if (mem_advance) state_nx = LSU_IDLE;
         default:  state_nx = LSU_IDLE;
      endcase
   end

   // Stall and per-cycle event strobes; ack wins over a coincident timeout
   always_comb begin
      cnt_last  = (cnt == CNT_W'(TIMEOUT - 1));
      mem_stall = op_valid && (state != LSU_DONE);
      issue     = (state == LSU_IDLE) && op_valid && !a_misalign;
      mis_set   = (state == LSU_IDLE) && op_valid && a_misalign;
      got_ack   = (state == LSU_WAIT) && dm_ack;
      tmo       = (state == LSU_WAIT) && !dm_ack && cnt_last;
      done_rel  = (state == LSU_DONE) && mem_advance;
   end

   // Bus, result and latched-request registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dm_req        <= 1'b0;
         dm_we         <= 1'b0;
         dm_addr       <= '0;
         dm_be         <= '0;
         dm_wdata      <= '0;
         mem_load_data <= '0;
         mem_misalign  <= 1'b0;
         mem_bus_err   <= 1'b0;
         cnt           <= '0;
         lat_size      <= SZ_WORD;
         lat_sign      <= 1'b0;
         lat_lo        <= '0;
      end else begin
         if (issue) begin
            dm_req   <= 1'b1;
            dm_we    <= is_store;
            dm_addr  <= EXMEMALUResult[31:2];
            dm_be    <= a_be;
            dm_wdata <= is_store ? a_wdata : '0;
            cnt      <= '0;
            lat_size <= live_size;
            lat_sign <= EXMEMMemRSign;
            lat_lo   <= EXMEMALUResult[1:0];
         end
         if (state == LSU_WAIT) cnt <= cnt + 1'b1;
         if (got_ack) begin
            dm_req <= 1'b0;
            if (!dm_we) mem_load_data <= a_load;
         end
         if (tmo) begin
            dm_req        <= 1'b0;
            mem_bus_err   <= 1'b1;
            mem_load_data <= '0;
         end
         if (mis_set) mem_misalign <= 1'b1;
         if (done_rel) begin
            mem_misalign <= 1'b0;
            mem_bus_err  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: the stimulus process queues expected
// bus requests and per-instruction results; a negedge monitor pops and
// compares them when the DUT raises dm_req or releases mem_stall.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        EXMEMMemRead, EXMEMMemWrite, EXMEMMemRSign, mem_advance;
   logic [1:0]  EXMEMMemRBits;
   logic [2:0]  EXMEMMemWrBits;
   logic [31:0] EXMEMALUResult, EXMEMMemWriteData;
   logic        dm_req, dm_we, dm_ack;
   logic [29:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata, dm_rdata, mem_load_data;
   logic        mem_stall, mem_misalign, mem_bus_err;

   mem_stage_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .EXMEMMemRead(EXMEMMemRead), .EXMEMMemWrite(EXMEMMemWrite),
      .EXMEMMemRBits(EXMEMMemRBits), .EXMEMMemRSign(EXMEMMemRSign),
      .EXMEMMemWrBits(EXMEMMemWrBits), .EXMEMALUResult(EXMEMALUResult),
      .EXMEMMemWriteData(EXMEMMemWriteData), .mem_advance(mem_advance),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_load_data(mem_load_data), .mem_stall(mem_stall),
      .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic        we;
      logic [29:0] addr;
      logic [3:0]  be;
      logic        chk_wd;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      string       nm;
      logic        mis;
      logic        err;
      logic [31:0] data;
      int          stall;
      int          req;
   } res_t;

   bus_t bus_q[$];
   res_t res_q[$];

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        op_active = 1'b0;
   logic [31:0] last_load = '0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic exp_bus(input string nm, input logic we, input logic [29:0] addr,
                          input logic [3:0] be, input logic chk_wd, input logic [31:0] wdata);
      bus_t b;
      b.nm = nm; b.we = we; b.addr = addr; b.be = be; b.chk_wd = chk_wd; b.wdata = wdata;
      bus_q.push_back(b);
   endtask

   task automatic exp_res(input string nm, input logic mis, input logic err,
                          input logic [31:0] data, input int stall, input int req);
      res_t r;
      r.nm = nm; r.mis = mis; r.err = err; r.data = data; r.stall = stall; r.req = req;
      res_q.push_back(r);
      last_load = data;
   endtask

   task automatic clear_inputs();
      EXMEMMemRead = 1'b0; EXMEMMemWrite = 1'b0; EXMEMMemRBits = 2'b00;
      EXMEMMemRSign = 1'b0; EXMEMMemWrBits = 3'b000; EXMEMALUResult = '0;
      EXMEMMemWriteData = '0;
   endtask

   task automatic apply(input logic mr, input logic mw, input logic [1:0] rb, input logic rs,
                        input logic [2:0] wb, input logic [31:0] addr, input logic [31:0] wd);
      EXMEMMemRead = mr; EXMEMMemWrite = mw; EXMEMMemRBits = rb; EXMEMMemRSign = rs;
      EXMEMMemWrBits = wb; EXMEMALUResult = addr; EXMEMMemWriteData = wd;
   endtask

   // ack_k: ack in the k-th cycle dm_req is high (0 = never); hold: extra DONE cycles
   task automatic run_op(input string nm, input logic mr, input logic mw, input logic [1:0] rb,
                         input logic rs, input logic [2:0] wb, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_k,
                         input int hold);
      int n;
      @(posedge clk); #1;
      apply(mr, mw, rb, rs, wb, addr, wd);
      op_active   = 1'b1;
      mem_advance = 1'b0;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!dm_req && mem_stall && n < 8);
      if (dm_req && ack_k > 0) begin
         repeat (ack_k - 1) @(negedge clk);
         dm_ack = 1'b1; dm_rdata = rd;
         @(posedge clk); #1;
         dm_ack = 1'b0; dm_rdata = 32'hA5A5_A5A5;
      end else begin
         n = 0;
         while (dm_req && n < 40) begin
            @(negedge clk); n++;
         end
      end
      @(negedge clk);
      check({nm, " stall in DONE"}, 32'(mem_stall), 32'd0);
      repeat (hold) @(posedge clk);
      @(posedge clk); #1 mem_advance = 1'b1;
      @(posedge clk); #1;
      mem_advance = 1'b0;
      clear_inputs();
      op_active = 1'b0;
   endtask

   // Monitor: compares bus fields on each dm_req rise and results when stall drops
   int   stall_cnt, req_cnt;
   logic prev_active = 1'b0, prev_stall = 1'b0, prev_req = 1'b0;
   always @(negedge clk) begin
      bus_t b;
      res_t r;
      if (op_active && !prev_active) begin
         stall_cnt = 0; req_cnt = 0; prev_stall = 1'b0; prev_req = 1'b0;
      end
      if (op_active) begin
         if (mem_stall) stall_cnt++;
         if (dm_req) req_cnt++;
         if (dm_req && !prev_req) begin
            if (bus_q.size() == 0) check("unexpected dm_req", 32'(dm_req), 32'd0);
            else begin
               b = bus_q.pop_front();
               check({b.nm, " dm_we"},   32'(dm_we),   32'(b.we));
               check({b.nm, " dm_addr"}, 32'(dm_addr), 32'(b.addr));
               check({b.nm, " dm_be"},   32'(dm_be),   32'(b.be));
               if (b.chk_wd) check({b.nm, " dm_wdata"}, dm_wdata, b.wdata);
            end
         end
         if (prev_stall && !mem_stall) begin
            if (res_q.size() == 0) check("unexpected completion", 32'(mem_stall), 32'd1);
            else begin
               r = res_q.pop_front();
               check({r.nm, " misalign"},    32'(mem_misalign), 32'(r.mis));
               check({r.nm, " bus_err"},     32'(mem_bus_err),  32'(r.err));
               check({r.nm, " load_data"},   mem_load_data,     r.data);
               check({r.nm, " stall cycles"}, 32'(stall_cnt),   32'(r.stall));
               check({r.nm, " req cycles"},  32'(req_cnt),      32'(r.req));
            end
         end
      end
      prev_active = op_active; prev_stall = mem_stall; prev_req = dm_req;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b0; mem_advance = 1'b0; dm_ack = 1'b0; dm_rdata = 32'hA5A5_A5A5;
      clear_inputs();
      repeat (2) @(negedge clk);
      check("reset dm_req",    32'(dm_req),       32'd0);
      check("reset dm_we",     32'(dm_we),        32'd0);
      check("reset dm_addr",   32'(dm_addr),      32'd0);
      check("reset dm_be",     32'(dm_be),        32'd0);
      check("reset dm_wdata",  dm_wdata,          32'd0);
      check("reset load_data", mem_load_data,     32'd0);
      check("reset misalign",  32'(mem_misalign), 32'd0);
      check("reset bus_err",   32'(mem_bus_err),  32'd0);
      check("reset stall",     32'(mem_stall),    32'd0);
      @(posedge clk); #1 rst = 1'b1;

      exp_bus("sw", 1'b1, 30'h401, 4'b1111, 1'b1, 32'hDEAD_BEEF);
      exp_res("sw", 1'b0, 1'b0, last_load, 4, 3);
      run_op("sw", 1'b0, 1'b1, 2'b00, 1'b0, 3'b100, 32'h1004, 32'hDEAD_BEEF, '0, 3, 0);

      exp_bus("lb s", 1'b0, 30'h800, 4'b1000, 1'b0, '0);
      exp_res("lb s", 1'b0, 1'b0, 32'hFFFF_FF80, 2, 1);
      run_op("lb s", 1'b1, 1'b0, 2'b10, 1'b1, 3'b000, 32'h2003, '0, 32'h80FF_1234, 1, 0);

      exp_bus("lhu", 1'b0, 30'h800, 4'b1100, 1'b0, '0);
      exp_res("lhu", 1'b0, 1'b0, 32'h0000_8001, 3, 2);
      run_op("lhu", 1'b1, 1'b0, 2'b01, 1'b0, 3'b000, 32'h2002, '0, 32'h8001_0000, 2, 0);

      exp_bus("lh s", 1'b0, 30'h800, 4'b0011, 1'b0, '0);
      exp_res("lh s", 1'b0, 1'b0, 32'hFFFF_F00D, 2, 1);
      run_op("lh s", 1'b1, 1'b0, 2'b01, 1'b1, 3'b000, 32'h2000, '0, 32'h1234_F00D, 1, 1);

      exp_bus("lbu", 1'b0, 30'h800, 4'b0010, 1'b0, '0);
      exp_res("lbu", 1'b0, 1'b0, 32'h0000_0080, 2, 1);
      run_op("lbu", 1'b1, 1'b0, 2'b10, 1'b0, 3'b000, 32'h2001, '0, 32'h0000_8000, 1, 0);

      exp_bus("sb", 1'b1, 30'h400, 4'b0010, 1'b1, 32'hABAB_ABAB);
      exp_res("sb", 1'b0, 1'b0, last_load, 3, 2);
      run_op("sb", 1'b0, 1'b1, 2'b00, 1'b0, 3'b001, 32'h1001, 32'h1234_56AB, 32'hFFFF_FFFF, 2, 0);

      exp_bus("sh", 1'b1, 30'h400, 4'b1100, 1'b1, 32'hBEEF_BEEF);
      exp_res("sh", 1'b0, 1'b0, last_load, 2, 1);
      run_op("sh", 1'b0, 1'b1, 2'b00, 1'b0, 3'b010, 32'h1002, 32'h0000_BEEF, '0, 1, 0);

      exp_bus("rd+wr", 1'b1, 30'h1400, 4'b0001, 1'b1, 32'h7777_7777);
      exp_res("rd+wr", 1'b0, 1'b0, last_load, 2, 1);
      run_op("rd+wr", 1'b1, 1'b1, 2'b00, 1'b1, 3'b001, 32'h5000, 32'h0000_0077, 32'h1111_1111, 1, 0);

      exp_bus("lw rsv", 1'b0, 30'h1800, 4'b1111, 1'b0, '0);
      exp_res("lw rsv", 1'b0, 1'b0, 32'hCAFE_F00D, 2, 1);
      run_op("lw rsv", 1'b1, 1'b0, 2'b11, 1'b1, 3'b000, 32'h6000, '0, 32'hCAFE_F00D, 1, 0);

      exp_res("lw mis", 1'b1, 1'b0, last_load, 1, 0);
      run_op("lw mis", 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 32'h3001, '0, '0, 1, 0);

      exp_res("sh mis", 1'b1, 1'b0, last_load, 1, 0);
      run_op("sh mis", 1'b0, 1'b1, 2'b00, 1'b0, 3'b010, 32'h3003, 32'h1234, '0, 1, 0);

      exp_bus("lw tmo", 1'b0, 30'h1000, 4'b1111, 1'b0, '0);
      exp_res("lw tmo", 1'b0, 1'b1, 32'h0, 17, 16);
      run_op("lw tmo", 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 32'h4000, '0, '0, 0, 5);

      exp_bus("ack@last", 1'b0, 30'h2400, 4'b1111, 1'b0, '0);
      exp_res("ack@last", 1'b0, 1'b0, 32'h0BAD_F00D, 17, 16);
      run_op("ack@last", 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 32'h9000, '0, 32'h0BAD_F00D, 16, 0);

      // Invalid store size and no memory op: never stall, never request
      @(posedge clk); #1 apply(1'b0, 1'b1, 2'b00, 1'b0, 3'b011, 32'h1000, 32'h55);
      repeat (3) begin
         @(negedge clk);
         check("bad wrbits stall", 32'(mem_stall), 32'd0);
         check("bad wrbits req",   32'(dm_req),    32'd0);
      end
      @(posedge clk); #1 clear_inputs();
      @(negedge clk);
      check("no-op stall", 32'(mem_stall), 32'd0);

      // Reset in the middle of WAIT abandons the access; a late ack is ignored
      exp_bus("rst lw", 1'b0, 30'h1C00, 4'b1111, 1'b0, '0);
      @(posedge clk); #1;
      apply(1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 32'h7000, '0);
      op_active = 1'b1;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!dm_req && n < 8);
      check("rst lw req seen", 32'(dm_req), 32'd1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1 check("rst async dm_req", 32'(dm_req), 32'd0);
      clear_inputs();
      op_active = 1'b0;
      #3 rst = 1'b1;
      @(negedge clk);
      dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1 dm_ack = 1'b0; dm_rdata = 32'hA5A5_A5A5;
      @(negedge clk);
      check("late ack dm_req",    32'(dm_req),      32'd0);
      check("late ack load_data", mem_load_data,    32'd0);
      check("late ack bus_err",   32'(mem_bus_err), 32'd0);
      check("late ack dm_be",     32'(dm_be),       32'd0);
      last_load = '0;

      exp_bus("lw post", 1'b0, 30'h2001, 4'b1111, 1'b0, '0);
      exp_res("lw post", 1'b0, 1'b0, 32'h1357_9BDF, 2, 1);
      run_op("lw post", 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 32'h8004, '0, 32'h1357_9BDF, 1, 0);

      repeat (3) @(negedge clk);
      check("bus queue drained",    32'(bus_q.size()), 32'd0);
      check("result queue drained", 32'(res_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
